// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   WIDTH_DEF : default operand/result width
//   CNT_W_DEF : default bit-index counter width, clog2(WIDTH_DEF)
//   state_t   : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
package sub_serial_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_cell.sv
// One-bit combinational full adder; the only arithmetic cell of the
// serial subtractor. The subtrahend bit is inverted by the caller.
//   i_a, i_b, i_cin : addend bits and carry-in
//   o_sum, o_cout   : sum bit and carry-out
module serial_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/sixteen_bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock
// through a single full-adder cell (b inverted, carry seeded with 1).
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted only in IDLE; a/b latched on that edge
//   busy       : high during the WIDTH serial cycles
//   done       : one-cycle pulse after the completion edge
//   diff       : a - b mod 2^WIDTH, held until the next completion
//   borrow     : unsigned a < b
//   zero       : diff == 0
//   overflow   : signed overflow of a - b
module sixteen_bit_serial_subtractor
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;
  logic             r_overflow;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  serial_sub_cell u_cell (
    .i_a   (r_a_sr[0]),
    .i_b   (~r_b_sr[0]),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Sum bits enter at the MSB so the first (LSB) result bit lands at bit 0
  // after WIDTH shifts.
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_carry    <= 1'b1;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_IDX) begin
            // On the MSB step r_carry is the carry into the MSB.
            r_diff     <= w_res_next;
            r_borrow   <= ~w_cout;
            r_overflow <= r_carry ^ w_cout;
            r_zero     <= (w_res_next == '0);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign zero     = r_zero;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_sixteen_bit_serial_subtractor.sv
module tb_sixteen_bit_serial_subtractor;
  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, borrow, zero, overflow;
  logic [15:0] diff;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t q[$];

  sixteen_bit_serial_subtractor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff",     32'(diff),     32'(e.d));
        chk("borrow",   32'(borrow),   32'(e.bo));
        chk("zero",     32'(zero),     32'(e.z));
        chk("overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input exp_t e);
    int bad;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
    end
    chk("busy_window", 32'(bad), 32'd0);
    @(negedge clk);
    chk("done_pulse", {30'd0, busy, done}, 32'd1);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad, t, first, second;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_outputs", {11'd0, busy, done, diff, borrow, zero, overflow}, 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    run_op(16'h1234, 16'h0234, '{d:16'h1000, bo:1'b0, z:1'b0, o:1'b0});
    run_op(16'h0000, 16'h0001, '{d:16'hFFFF, bo:1'b1, z:1'b0, o:1'b0});
    run_op(16'h8000, 16'h0001, '{d:16'h7FFF, bo:1'b0, z:1'b0, o:1'b1});
    run_op(16'hABCD, 16'hABCD, '{d:16'h0000, bo:1'b0, z:1'b1, o:1'b0});
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (diff !== 16'h0000 || zero !== 1'b1) bad++;
    end
    chk("hold_idle", 32'(bad), 32'd0);

    // Back-to-back with start held high; operands change after acceptance
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    q.push_back('{d:16'h0002, bo:1'b0, z:1'b0, o:1'b0});
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF;
    q.push_back('{d:16'h0000, bo:1'b0, z:1'b1, o:1'b0});
    t = 1; first = -1; second = -1;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) begin
        if (first < 0) first = t;
        else second = t;
      end
      if (second >= 0) break;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    a = '0; b = '0;
    chk("b2b_first_latency", 32'(first), 32'd17);
    chk("b2b_period", 32'(second - first), 32'd18);

    // Reset during SHIFT cycle 8
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {11'd0, busy, done, diff, borrow, zero, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_done_after_abort", 32'(bad), 32'd0);

    run_op(16'h0100, 16'h0001, '{d:16'h00FF, bo:1'b0, z:1'b0, o:1'b0});

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
